inport_fifo: RTL and testbench



---
 rtl/io_port_pkg.sv | 15 +
 rtl/fifo_store.sv | 30 +++
 rtl/inport_fifo.sv | 115 +++++++++++
 tb/tb_inport_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared types and helpers for the CPU input-port blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_port_pkg;

    localparam int IO_WORD_W = 32;

    typedef logic [IO_WORD_W-1:0] io_word_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_store.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
module fifo_store
    import io_port_pkg::*;
#(
    parameter int WIDTH = IO_WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Contents are never reset: stale words are unreachable once pointers clear.
    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming word into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inport_fifo.sv
// DEPTH-entry show-ahead FIFO between an input device and the CPU bus, with sticky ovf/udf.
// Latency: a pushed word appears on q one cycle after its push edge.
// Backpressure: dev_ready = !full from registered count; pushes while full are dropped and flag ovf.
// Optional irq output (count >= IRQ_THRESHOLD) is built when INPORT_FIFO_IRQ_EN is defined.
module inport_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH         = IO_WORD_W,
    parameter int DEPTH         = 4,
    parameter int IRQ_THRESHOLD = 1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      dev_valid,
    input  logic [WIDTH-1:0]          dev_data,
    output logic                      dev_ready,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          q,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    input  logic                      stat_clr,
    output logic                      ovf,
    output logic                      udf
`ifdef INPORT_FIFO_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inport_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_word;
    logic             push;
    logic             pop;

    // Flags come only from the registered count, so no input reaches them combinationally.
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign dev_ready = !full;

    assign push = dev_valid && !full;
    assign pop  = rd_en && !empty;

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, occupancy and sticky status; clr overrides every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            // A new event in the same cycle as stat_clr keeps the flag set.
            ovf   <= (dev_valid && full) || (ovf && !stat_clr);
            udf   <= (rd_en && empty) || (udf && !stat_clr);
        end
    end

`ifdef INPORT_FIFO_IRQ_EN
    if (IRQ_THRESHOLD < 1 || IRQ_THRESHOLD > DEPTH) begin : g_bad_thr
        $error("inport_fifo: IRQ_THRESHOLD must be within 1..DEPTH");
    end

    // irq tracks the occupancy that count takes on at the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            irq <= 1'b0;
        end else begin
            irq <= (count_nxt >= CW'(IRQ_THRESHOLD));
        end
    end
`endif

    fifo_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (dev_data),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    // Show-ahead head word, forced to zero when nothing is queued.
    assign q = empty ? '0 : head_word;

endmodule

// File: tb/tb_inport_fifo.sv
// Self-checking bench for inport_fifo (DEPTH=4, WIDTH=32) against a queue-based model.
// Inputs change #1 after the rising edge; outputs are compared in the same settled window.
// Build with INPORT_FIFO_IRQ_EN defined to also cover irq (IRQ_THRESHOLD=2).
module tb_inport_fifo;
    import io_port_pkg::*;

    localparam int DEPTH   = 4;
    localparam int IRQ_THR = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        dev_valid = 1'b0;
    io_word_t    dev_data = '0;
    logic        dev_ready;
    logic        rd_en = 1'b0;
    io_word_t    q;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        stat_clr = 1'b0;
    logic        ovf;
    logic        udf;
`ifdef INPORT_FIFO_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queued words in FIFO order plus the two sticky flags.
    io_word_t mq[$];
    bit       m_ovf = 1'b0;
    bit       m_udf = 1'b0;

    inport_fifo #(
        .WIDTH         (32),
        .DEPTH         (DEPTH),
        .IRQ_THRESHOLD (IRQ_THR)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ready (dev_ready),
        .rd_en     (rd_en),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .stat_clr  (stat_clr),
        .ovf       (ovf),
        .udf       (udf)
`ifdef INPORT_FIFO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic io_word_t exp_q();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Apply one cycle of inputs, let the edge happen, advance the model, then idle the inputs.
    task automatic drive(input bit v, input io_word_t d, input bit r, input bit sc, input bit c);
        bit was_full;
        bit was_empty;
        dev_valid = v;
        dev_data  = d;
        rd_en     = r;
        stat_clr  = sc;
        clr       = c;
        @(posedge clk);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ovf = (v && was_full) ? 1'b1 : (sc ? 1'b0 : m_ovf);
            m_udf = (r && was_empty) ? 1'b1 : (sc ? 1'b0 : m_udf);
            if (r && !was_empty) void'(mq.pop_front());
            if (v && !was_full) mq.push_back(d);
        end
        #1;
        dev_valid = 1'b0;
        dev_data  = '0;
        rd_en     = 1'b0;
        stat_clr  = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_tests++; if (dev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dev_ready got=%b exp=1", dev_ready); end
        n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q got=%h exp=0", q); end
        n_tests++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", ovf, udf); end
`ifdef INPORT_FIFO_IRQ_EN
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    endtask

    task automatic test_fill_overflow_drain();
        io_word_t vals [4];
        io_word_t after_pop [4];
        vals      = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        after_pop = '{32'hB2, 32'hC3, 32'hD4, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                n_tests++; if (q !== 32'hA1) begin n_fail++; $display("FAIL first_push_q got=%h exp=a1", q); end
            end
        end
        n_tests++; if (count !== 3'd4 || full !== 1'b1 || dev_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_state got cnt=%0d full=%b rdy=%b exp 4/1/0", count, full, dev_ready);
        end
        drive(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
        n_tests++; if (ovf !== 1'b1 || count !== 3'd4 || q !== 32'hA1) begin
            n_fail++; $display("FAIL overflow got ovf=%b cnt=%0d q=%h exp 1/4/a1", ovf, count, q);
        end
        drive(1'b1, 32'hEE, 1'b0, 1'b1, 1'b0);
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_beats_clr got=%b exp=1", ovf); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL stat_clr_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_tests++; if (q !== after_pop[i]) begin n_fail++; $display("FAIL drain_q%0d got=%h exp=%h", i, q, after_pop[i]); end
        end
        n_tests++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got e=%b cnt=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, io_word_t'(32'h10 + i), 1'b1, 1'b0, 1'b0);
            n_tests++; if (count !== 3'd2 || q !== exp_q()) begin
                n_fail++; $display("FAIL b2b_%0d got cnt=%0d q=%h exp 2/%h", i, count, q, exp_q());
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h15) begin n_fail++; $display("FAIL b2b_tail got=%h exp=15", q); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_underflow();
        drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        n_tests++; if (udf !== 1'b1 || count !== 3'd1 || q !== 32'h55) begin
            n_fail++; $display("FAIL underflow got udf=%b cnt=%0d q=%h exp 1/1/55", udf, count, q);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL stat_clr_udf got=%b exp=0", udf); end
    endtask

    task automatic test_clr_midstream();
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_clr_count got=%0d exp=3", count); end
`ifdef INPORT_FIFO_IRQ_EN
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_clr_irq got=%b exp=1", irq); end
`endif
        drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
        n_tests++; if (count !== 3'd0 || q !== 32'h0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL clr_mid got cnt=%0d q=%h e=%b exp 0/0/1", count, q, empty);
        end
`ifdef INPORT_FIFO_IRQ_EN
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL post_clr_irq got=%b exp=0", irq); end
`endif
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 2);
            n_tests++;
            if (count !== 3'(mq.size()) || q !== exp_q() || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) || dev_ready !== (mq.size() != DEPTH) ||
                ovf !== m_ovf || udf !== m_udf
`ifdef INPORT_FIFO_IRQ_EN
                || irq !== (mq.size() >= IRQ_THR)
`endif
            ) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand_%0d got cnt=%0d q=%h ovf=%b udf=%b exp cnt=%0d q=%h ovf=%b udf=%b",
                                       i, count, q, ovf, udf, mq.size(), exp_q(), m_ovf, m_udf);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow_drain();
        test_back_to_back();
        test_underflow();
        test_clr_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
